cml_video_to_axis: RTL and testbench

// - Consumes decoded CameraLink video (LVAL/FVAL/DVAL + packed port data) in the pixel_clk domain.
// - Emits AXI4-Stream video: tuser = start of frame (SOF), tlast = end of line (EOL).
// - Sits directly downstream of the CameraLink bit-allocation decode stage.
// - Provides small elastic buffering, frame alignment, overflow handling and line/frame geometry measurement.

---
 rtl/cml_pkg.sv | 15 +
 rtl/cml_sync_fifo.sv | 59 +++++
 rtl/cml_video_to_axis.sv | 206 ++++++++++++++++++++
 tb/tb_cml_video_to_axis.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cml_pkg.sv
// Shared definitions for the CameraLink-to-AXI4-Stream video bridge: FSM encodings and default widths.
// No logic and no latency of its own; it only supplies types and constants.
package cml_pkg;

    localparam int PIX_W_DEF = 24;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        S_WAIT_LOW = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_FRAME    = 2'd2,
        S_DROP     = 2'd3
    } state_t;

endpackage

// File: rtl/cml_sync_fifo.sv
// Single-clock FWFT FIFO: a write shows up on o_rd_dat right after its edge (0-cycle read latency).
// Backpressure: a write while full is accepted only when a read occurs on the same edge.
module cml_sync_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_dat,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_dat,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_rd     = i_rd_en & ~o_empty;
    assign w_wr     = i_wr_en & (~o_full | w_rd);
    // Gate the read word so the stream reads 0 while nothing is queued.
    assign o_rd_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cml_video_to_axis.sv
// CameraLink LVAL/FVAL/DVAL video to AXI4-Stream (tuser=SOF, tlast=EOL); pixel at edge t enters FIFO at t+2.
// A write into a full FIFO drops the rest of that frame and sets o_overflow; CML_DVAL_QUAL_EN makes DVAL qualify pixels.
module cml_video_to_axis
    import cml_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             pixel_clk,
    input  logic             reset_n,
    input  logic             i_fval,
    input  logic             i_lval,
    input  logic             i_dval,
    input  logic [PIX_W-1:0] i_pix,
    output logic [PIX_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] o_line_pixels,
    output logic [CNT_W-1:0] o_frame_lines,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_overflow
);

`ifdef CML_DVAL_QUAL_EN
    localparam bit DVAL_QUAL = 1'b1;
`else
    localparam bit DVAL_QUAL = 1'b0;
`endif

    state_t           r_state;
    logic             r_primed;
    logic             r_fval;
    logic             r_lval;
    logic             r_dval;
    logic             r_fval_d;
    logic             r_lval_d;
    logic [PIX_W-1:0] r_pix;
    logic [PIX_W-1:0] r_hold_pix;
    logic             r_hold_vld;
    logic             r_hold_user;
    logic             r_sof_pend;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_line_pixels;
    logic [CNT_W-1:0] r_frame_lines;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_overflow;

    logic             w_pix_en;
    logic             w_lval_rise;
    logic             w_lval_fall;
    logic             w_fval_rise;
    logic             w_in_frame;
    logic             w_eol;
    logic             w_wr_try;
    logic             w_blocked;
    logic             w_wr_en;
    logic             w_load;
    logic             w_rd_en;
    logic             w_full;
    logic             w_empty;
    logic [PIX_W+1:0] w_wr_dat;
    logic [PIX_W+1:0] w_rd_dat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_pix_en    = r_fval & r_lval & (r_dval | ~DVAL_QUAL);
    assign w_lval_rise = r_lval & ~r_lval_d;
    assign w_lval_fall = ~r_lval & r_lval_d;
    assign w_fval_rise = r_fval & ~r_fval_d;
    // WAIT_SOF is only ever entered with fval low, so fval high there is the frame start.
    assign w_in_frame  = (r_state == S_FRAME) | ((r_state == S_WAIT_SOF) & r_fval);
    assign w_eol       = ~r_lval | ~r_fval;

    // The held pixel leaves when the next pixel arrives or when the line/frame ends.
    assign w_wr_try  = (r_state == S_FRAME) & r_hold_vld & (w_pix_en | w_eol);
    assign w_blocked = w_wr_try & w_full & ~w_rd_en;
    assign w_wr_en   = w_wr_try & ~w_blocked;
    assign w_load    = w_in_frame & w_pix_en & ~w_blocked;
    assign w_wr_dat  = {r_hold_user, w_eol, r_hold_pix};

    assign w_rd_en       = ~w_empty & m_axis_tready;
    assign m_axis_tvalid = ~w_empty;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = w_rd_dat;

    assign o_line_pixels = r_line_pixels;
    assign o_frame_lines = r_frame_lines;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_overflow    = r_overflow;

    cml_sync_fifo #(
        .W     (PIX_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (pixel_clk),
        .reset_n  (reset_n),
        .i_wr_en  (w_wr_en),
        .i_wr_dat (w_wr_dat),
        .i_rd_en  (w_rd_en),
        .o_rd_dat (w_rd_dat),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            r_state       <= S_WAIT_LOW;
            r_primed      <= 1'b0;
            r_fval        <= 1'b0;
            r_lval        <= 1'b0;
            r_dval        <= 1'b0;
            r_fval_d      <= 1'b0;
            r_lval_d      <= 1'b0;
            r_pix         <= '0;
            r_hold_pix    <= '0;
            r_hold_vld    <= 1'b0;
            r_hold_user   <= 1'b0;
            r_sof_pend    <= 1'b1;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_line_pixels <= '0;
            r_frame_lines <= '0;
            r_frame_cnt   <= '0;
            r_overflow    <= 1'b0;
        end else begin
            // r_primed keeps WAIT_LOW from trusting the reset value of r_fval.
            r_primed <= 1'b1;
            r_fval   <= i_fval;
            r_lval   <= i_lval;
            r_dval   <= i_dval;
            r_pix    <= i_pix;
            r_fval_d <= r_fval;
            r_lval_d <= r_lval;

            if (w_load) begin
                r_hold_pix  <= r_pix;
                r_hold_user <= r_sof_pend | (r_state == S_WAIT_SOF);
                r_hold_vld  <= 1'b1;
            end else if (w_wr_try) begin
                r_hold_vld  <= 1'b0;
            end

            if (w_load) begin
                r_sof_pend <= 1'b0;
            end else if (r_state != S_FRAME) begin
                r_sof_pend <= 1'b1;
            end

            if (w_lval_rise) begin
                r_pix_cnt <= {{(CNT_W-1){1'b0}}, w_pix_en};
            end else if (w_pix_en) begin
                r_pix_cnt <= sat_inc(r_pix_cnt);
            end

            if (w_fval_rise) begin
                r_line_cnt <= '0;
            end else if (w_lval_fall) begin
                r_line_cnt <= sat_inc(r_line_cnt);
            end

            if (w_blocked) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                S_WAIT_LOW: begin
                    if (r_primed && !r_fval) begin
                        r_state <= S_WAIT_SOF;
                    end
                end
                S_WAIT_SOF: begin
                    if (r_fval) begin
                        r_state <= S_FRAME;
                    end
                end
                S_FRAME: begin
                    if (w_lval_fall) begin
                        r_line_pixels <= r_pix_cnt;
                    end
                    if (!r_fval) begin
                        r_state <= S_WAIT_SOF;
                        // A line still open when fval drops (truncated or coincident) counts too.
                        r_frame_lines <= r_lval_d ? sat_inc(r_line_cnt) : r_line_cnt;
                        if (!w_blocked) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end else if (w_blocked) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (!r_fval) begin
                        r_state <= S_WAIT_SOF;
                    end
                end
                default: r_state <= S_WAIT_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_cml_video_to_axis.sv
// Directed frames into cml_video_to_axis; expected beats are queued at stimulus time and a monitor checks the stream.
`timescale 1ns/1ps
module tb_cml_video_to_axis;

    localparam int PIX_W = 24;
    localparam int CNT_W = 16;
`ifdef CML_DVAL_QUAL_EN
    localparam bit QUAL = 1'b1;
`else
    localparam bit QUAL = 1'b0;
`endif

    typedef struct packed {
        logic             user;
        logic             last;
        logic [PIX_W-1:0] dat;
    } beat_t;

    logic             pixel_clk = 1'b0;
    logic             reset_n;
    logic             i_fval;
    logic             i_lval;
    logic             i_dval;
    logic [PIX_W-1:0] i_pix;
    logic [PIX_W-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tuser;
    logic             m_axis_tlast;
    logic [CNT_W-1:0] o_line_pixels;
    logic [CNT_W-1:0] o_frame_lines;
    logic [CNT_W-1:0] o_frame_cnt;
    logic             o_overflow;

    beat_t exp_q[$];
    int    n_pass     = 0;
    int    n_total    = 0;
    bit    toggle_rdy = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    cml_video_to_axis #(.PIX_W(PIX_W), .FIFO_DEPTH(16), .CNT_W(CNT_W)) dut (
        .pixel_clk     (pixel_clk),
        .reset_n       (reset_n),
        .i_fval        (i_fval),
        .i_lval        (i_lval),
        .i_dval        (i_dval),
        .i_pix         (i_pix),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .o_line_pixels (o_line_pixels),
        .o_frame_lines (o_frame_lines),
        .o_frame_cnt   (o_frame_cnt),
        .o_overflow    (o_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Every presented beat must match the queue head, whether or not it is accepted this cycle.
    always @(negedge pixel_clk) begin
        if (reset_n === 1'b1 && m_axis_tvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_beat: got data %0h user %0b last %0b, expected no beat",
                         m_axis_tdata, m_axis_tuser, m_axis_tlast);
            end else begin
                check("beat_data", 32'(m_axis_tdata), 32'(exp_q[0].dat));
                check("beat_user", 32'(m_axis_tuser), 32'(exp_q[0].user));
                check("beat_last", 32'(m_axis_tlast), 32'(exp_q[0].last));
                if (m_axis_tready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge pixel_clk);
        #1;
        if (toggle_rdy) m_axis_tready = ~m_axis_tready;
    endtask

    task automatic idle(input int n);
        i_fval = 1'b0;
        i_lval = 1'b0;
        i_dval = 1'b0;
        repeat (n) cyc();
    endtask

    // cut_px>0: on the last line fval drops after cut_px pixels while lval stays high.
    task automatic send_frame(input logic [7:0] tag, input int lines, input int ppl,
                              input bit hole, input int cut_px, input int n_push);
        bit    sof;
        int    pushed;
        beat_t b;
        sof    = 1'b1;
        pushed = 0;
        for (int l = 0; l < lines; l++) begin
            bit cut_here;
            int np;
            cut_here = (cut_px > 0) && (l == lines - 1);
            np       = cut_here ? cut_px : ppl;
            for (int p = 0; p < np; p++) begin
                bit fwd;
                i_fval = 1'b1;
                i_lval = 1'b1;
                i_dval = !(hole && p == 2);
                i_pix  = {tag, 8'(l), 8'(p)};
                fwd    = i_dval || !QUAL;
                if (fwd && pushed < n_push) begin
                    b.user = sof;
                    b.last = (p == np - 1);
                    b.dat  = i_pix;
                    exp_q.push_back(b);
                    pushed++;
                end
                if (fwd) sof = 1'b0;
                cyc();
            end
            if (cut_here) begin
                i_fval = 1'b0;
                cyc();
            end
            i_lval = 1'b0;
            i_dval = 1'b0;
            i_fval = !cut_here;
            repeat (2) cyc();
        end
        idle(3);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        i_fval        = 1'b0;
        i_lval        = 1'b0;
        i_dval        = 1'b0;
        i_pix         = '0;
        m_axis_tready = 1'b1;
        repeat (4) cyc();
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tuser_tlast", 32'({m_axis_tuser, m_axis_tlast}), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_counters", 32'(o_line_pixels | o_frame_lines | o_frame_cnt), 32'd0);
        reset_n = 1'b1;
        idle(3);

        send_frame(8'hA1, 3, 4, 1'b0, 0, 1000);
        wait_drain("drain_basic");
        check("basic_line_pixels", 32'(o_line_pixels), 32'd4);
        check("basic_frame_lines", 32'(o_frame_lines), 32'd3);
        check("basic_frame_cnt", 32'(o_frame_cnt), 32'd1);

        send_frame(8'hB2, 3, 4, 1'b1, 0, 1000);
        wait_drain("drain_dval");
        check("dval_line_pixels", 32'(o_line_pixels), QUAL ? 32'd3 : 32'd4);
        check("dval_frame_cnt", 32'(o_frame_cnt), 32'd2);

        toggle_rdy = 1'b1;
        send_frame(8'hC3, 3, 4, 1'b0, 0, 1000);
        wait_drain("drain_toggle");
        toggle_rdy    = 1'b0;
        m_axis_tready = 1'b1;
        check("toggle_overflow", 32'(o_overflow), 32'd0);
        check("toggle_frame_cnt", 32'(o_frame_cnt), 32'd3);

        send_frame(8'hD4, 2, 4, 1'b0, 2, 1000);
        wait_drain("drain_trunc");
        check("trunc_frame_lines", 32'(o_frame_lines), 32'd2);
        check("trunc_line_pixels", 32'(o_line_pixels), 32'd4);
        check("trunc_frame_cnt", 32'(o_frame_cnt), 32'd4);

        m_axis_tready = 1'b0;
        send_frame(8'hE5, 1, 32, 1'b0, 0, 16);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        check("ovf_frame_cnt", 32'(o_frame_cnt), 32'd4);
        m_axis_tready = 1'b1;
        wait_drain("drain_ovf");
        repeat (3) cyc();
        check("ovf_fifo_empty", 32'(m_axis_tvalid), 32'd0);

        send_frame(8'hF6, 3, 4, 1'b0, 0, 1000);
        wait_drain("drain_after_ovf");
        check("after_ovf_frame_cnt", 32'(o_frame_cnt), 32'd5);
        check("after_ovf_frame_lines", 32'(o_frame_lines), 32'd3);

        i_fval  = 1'b1;
        i_lval  = 1'b1;
        i_dval  = 1'b1;
        reset_n = 1'b0;
        repeat (3) cyc();
        check("midrst_overflow", 32'(o_overflow), 32'd0);
        check("midrst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        reset_n = 1'b1;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) begin
                i_lval = 1'b1;
                i_pix  = {8'h99, 8'(l), 8'(p)};
                cyc();
            end
            i_lval = 1'b0;
            repeat (2) cyc();
        end
        check("midrst_no_beats", 32'(m_axis_tvalid), 32'd0);
        idle(3);
        send_frame(8'hA7, 3, 4, 1'b0, 0, 1000);
        wait_drain("drain_midrst");
        check("midrst_next_frame_cnt", 32'(o_frame_cnt), 32'd1);
        check("midrst_line_pixels", 32'(o_line_pixels), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
